// File: rtl/nott_pulse_deser.sv
// Deserialiser for NOTT output pulses: one bit per eval window, packed LSB-first into
// WIDTH-bit words on a valid/ready port, with double-pulse and overrun fault flags.
module nott_pulse_deser #(
    parameter  int WIDTH = 8,
    parameter  int ERR_W = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             eval_in,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [IDX_W-1:0] bit_idx,
    output logic             overrun,
    output logic [ERR_W-1:0] dbl_cnt
);

    logic             pend_q, pend_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic [ERR_W-1:0] dbl_q, dbl_d;

    logic             bit_v, last, complete, load;
    logic [WIDTH-1:0] word_full;

    always_comb begin
        // A pulse coincident with eval still belongs to the window being closed.
        bit_v     = pend_q | pulse_in;
        last      = (bit_idx_q == IDX_W'(WIDTH - 1));
        word_full = shreg_q;
        word_full[bit_idx_q] = bit_v;
        complete  = eval_in & last;
        // A completed word may take the output slot if it is empty or being drained now.
        load      = complete & (~valid_q | word_ready);

        pend_d    = eval_in ? 1'b0 : (pend_q | pulse_in);
        dbl_d     = dbl_q;
        if (pulse_in && pend_q && (dbl_q != {ERR_W{1'b1}}))
            dbl_d = dbl_q + 1'b1;

        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        if (eval_in) begin
            shreg_d   = last ? '0 : word_full;
            bit_idx_d = last ? '0 : bit_idx_q + 1'b1;
        end

        word_d  = load ? word_full : word_q;
        valid_d = load | (valid_q & ~word_ready);
        ovr_d   = ovr_q | (complete & ~load);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= 1'b0;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            dbl_q     <= '0;
        end else begin
            pend_q    <= pend_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            dbl_q     <= dbl_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign bit_idx    = bit_idx_q;
    assign overrun    = ovr_q;
    assign dbl_cnt    = dbl_q;

endmodule

// File: tb/tb_nott_pulse_deser.sv
// Directed bench for nott_pulse_deser (WIDTH=4), two instances differing in ERR_W,
// checked every cycle against a window/pulse-count model plus literal expectations.
module tb_nott_pulse_deser;

    logic       clk = 1'b0;
    logic       rst, pulse_in, eval_in, word_ready;
    logic [3:0] w1, w2;
    logic       v1, v2, o1, o2;
    logic [1:0] i1, i2;
    logic [7:0] d1;
    logic [1:0] d2;

    int tests = 0;
    int fails = 0;

    // Model state: pulses seen in the open window, bits gathered so far, output slot.
    int         m_np, m_nbits, m_dbl8, m_dbl2;
    logic [3:0] m_acc, m_word;
    logic       m_valid, m_ovr;

    always #5 clk = ~clk;

    nott_pulse_deser #(.WIDTH(4), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .eval_in(eval_in),
        .word_out(w1), .word_valid(v1), .word_ready(word_ready),
        .bit_idx(i1), .overrun(o1), .dbl_cnt(d1));

    nott_pulse_deser #(.WIDTH(4), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .eval_in(eval_in),
        .word_out(w2), .word_valid(v2), .word_ready(word_ready),
        .bit_idx(i2), .overrun(o2), .dbl_cnt(d2));

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit full;
        if (rst) begin
            m_np = 0; m_nbits = 0; m_dbl8 = 0; m_dbl2 = 0;
            m_acc = '0; m_word = '0; m_valid = 1'b0; m_ovr = 1'b0;
            return;
        end
        if (pulse_in) begin
            if (m_np > 0) begin
                if (m_dbl8 < 255) m_dbl8++;
                if (m_dbl2 < 3)   m_dbl2++;
            end
            m_np++;
        end
        full = 1'b0;
        if (eval_in) begin
            m_acc[m_nbits] = (m_np > 0);
            m_np = 0;
            m_nbits++;
            full = (m_nbits == 4);
        end
        if (full) begin
            if (!m_valid || word_ready) begin
                m_word  = m_acc;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
            m_acc   = '0;
            m_nbits = 0;
        end else if (m_valid && word_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: advance model, let the DUT clock, compare on the falling edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk("valid", v1, m_valid);
        if (m_valid) chk("word", w1, m_word);
        chk("bit_idx", i1, m_nbits);
        chk("overrun", o1, m_ovr);
        chk("dbl8", d1, m_dbl8);
        chk("valid2", v2, m_valid);
        if (m_valid) chk("word2", w2, m_word);
        chk("bit_idx2", i2, m_nbits);
        chk("dbl2", d2, m_dbl2);
    endtask

    // A window: np pulses on separate cycles, one idle cycle, then eval (optionally with a pulse).
    task automatic win(input int np, input bit coinc);
        for (int k = 0; k < np; k++) begin
            pulse_in = 1'b1; step();
        end
        pulse_in = 1'b0; step();
        pulse_in = coinc; eval_in = 1'b1; step();
        pulse_in = 1'b0; eval_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pulse_in = 1'b0; eval_in = 1'b0; word_ready = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_word", w1, 0); chk("rst_valid", v1, 0); chk("rst_idx", i1, 0);
        chk("rst_ovr", o1, 0); chk("rst_dbl", d1, 0);

        // Clean word 1,0,1,1 with ready held high.
        win(1, 0); win(0, 0); win(1, 0); win(1, 0);
        chk("t1_word", w1, 4'b1101); chk("t1_valid", v1, 1);
        step();
        chk("t1_valid_drop", v1, 0); chk("t1_idx", i1, 0);
        chk("t1_ovr", o1, 0); chk("t1_dbl", d1, 0);

        // Pulses coincident with every eval.
        for (int k = 0; k < 4; k++) win(0, 1);
        chk("t2_word", w1, 4'b1111); chk("t2_dbl", d1, 0);
        step();

        // Double pulses, then saturation of the narrow counter.
        do_reset();
        win(3, 0); win(0, 0); win(0, 0); win(0, 0);
        chk("t3_word", w1, 4'b0001); chk("t3_dbl", d1, 2); chk("t3_dbl2", d2, 2);
        for (int k = 0; k < 4; k++) win(3, 0);
        chk("t3_word_b", w1, 4'b1111); chk("t3_sat8", d1, 10); chk("t3_sat2", d2, 3);
        step();

        // Backpressure: second word dropped, first word held.
        do_reset();
        word_ready = 1'b0;
        win(1, 0); win(1, 0); win(0, 0); win(0, 0);
        win(0, 0); win(0, 0); win(1, 0); win(1, 0);
        chk("t4_word", w1, 4'b0011); chk("t4_valid", v1, 1); chk("t4_ovr", o1, 1);
        word_ready = 1'b1; step();
        chk("t4_drain", v1, 0); chk("t4_ovr_sticky", o1, 1);
        step();
        chk("t4_no_1100", v1, 0);

        // Accept the held word on the same edge the next one completes.
        do_reset();
        word_ready = 1'b0;
        win(1, 0); win(0, 0); win(1, 0); win(0, 0);
        win(0, 0); win(1, 0); win(0, 0);
        pulse_in = 1'b1; step();
        pulse_in = 1'b0; step();
        chk("t5_held", w1, 4'b0101);
        word_ready = 1'b1; eval_in = 1'b1; step();
        eval_in = 1'b0;
        chk("t5_valid", v1, 1); chk("t5_word", w1, 4'b1010); chk("t5_ovr", o1, 0);
        step();

        // Reset with a partial word pending.
        win(1, 0); win(1, 0);
        chk("t6_idx", i1, 2);
        do_reset();
        chk("t6_word0", w1, 0); chk("t6_idx0", i1, 0); chk("t6_valid0", v1, 0);
        win(0, 0); win(1, 0); win(0, 0); win(0, 0);
        chk("t6_word", w1, 4'b0010); chk("t6_valid", v1, 1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nott_pulse_deser.md
Name: nott_pulse_deser

Overview:
- Downstream consumer of the clocked inverter (NOTT) cell's output pulse stream in the synchronous RTL model of the RSFQ chain.
- Groups NOTT output pulses into evaluation windows, one window per NOTT clock pulse. Each window becomes one bit.
- Packs WIDTH bits LSB-first into a word and presents it on a valid/ready interface to the digital readout.
- Flags protocol faults: double pulses inside one window, and word overrun.

Parameters:
- WIDTH, 8, bits per assembled word (2..32).
- ERR_W, 8, width of the saturating double-pulse counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pulse_in  in  1  one-cycle-high event: NOTT output pulse.
- eval_in  in  1  one-cycle-high strobe: NOTT clock pulse; closes the current window.
- word_out  out  WIDTH  assembled word; bit 0 = first window.
- word_valid  out  1  word_out holds an unconsumed word.
- word_ready  in  1  consumer accepts word_out when high with word_valid.
- bit_idx  out  clog2(WIDTH)  number of bits already captured in the current partial word.
- overrun  out  1  sticky: a completed word was dropped.
- dbl_cnt  out  ERR_W  saturating count of extra pulses inside a window.

Behaviour:
- Reset (rst high at clk edge) wins over all other inputs. It clears all of the following to 0:
  - word_out, word_valid, bit_idx, overrun, dbl_cnt
  - the window-pending flag and the shift register
  - any partial word, which is discarded.
- Window definition:
  - A window spans from the cycle after an eval_in up to and including the next eval_in cycle.
  - A pulse_in in the same cycle as eval_in belongs to the window being closed.
- Pending flag:
  - Set by pulse_in.
  - Cleared at eval_in after its value is captured.
- Bit value at eval_in = pending OR pulse_in.
  - 1 means the NOTT fired, i.e. its logical input was 0.
  - No inversion is applied here.
- Double pulse:
  - Condition: pulse_in while pending already set, or a second pulse in the eval cycle with pending set.
  - dbl_cnt increments by 1 and saturates at 2^ERR_W-1.
  - The bit is still recorded as 1.
- Packing:
  - The captured bit is written to position bit_idx.
  - bit_idx increments, wrapping to 0 after WIDTH-1.
  - No bits are lost across the wrap.
- Word completion (eval_in with bit_idx = WIDTH-1):
  - If word_valid=0, or word_valid=1 with word_ready=1 in the same cycle: load word_out, and word_valid=1 from the next cycle. Latency is 1 cycle after the closing eval.
  - Otherwise: the new word is discarded, overrun is set (sticky until rst), and word_out and word_valid are unchanged.
- Handshake:
  - Transfer occurs on a clk edge with word_valid & word_ready.
  - word_valid drops the next cycle unless a new word is loaded in the same cycle; in that case it stays 1 with the new data.
  - word_out stays stable while word_valid=1 and word_ready=0.
- word_ready with word_valid=0 has no effect.
- pulse_in with no eval_in ever does not change bit_idx.
- eval_in with no pulses records 0 bits.

Test Plan:
- Clean word, WIDTH=4, word_ready=1:
  - Stimulus: windows with pulse pattern 1,0,1,1 (pulse 2 cycles before each eval).
  - Response: word_out=4'b1101, word_valid high for exactly 1 cycle, one cycle after the 4th eval; bit_idx returns 0; overrun=0; dbl_cnt=0.
- Coincident pulse:
  - Stimulus: pulse_in and eval_in in the same cycle for all 4 windows.
  - Response: word_out=4'b1111, dbl_cnt=0.
- Double pulse:
  - Stimulus: 3 pulses in window 0, none elsewhere.
  - Response: word_out=4'b0001, dbl_cnt=2.
  - Also with ERR_W=2 and 5 such windows: dbl_cnt=3 (saturated).
- Backpressure/overrun, word_ready=0:
  - Stimulus: words 4'b0011 then 4'b1100.
  - Response: word_out stays 4'b0011 with valid held; overrun=1.
  - Then word_ready=1: 4'b0011 accepted; valid drops; 1100 is never presented.
- Accept-and-load same cycle:
  - Stimulus: word_ready=1 on the same edge that the 2nd word completes.
  - Response: word_valid stays 1 continuously; word_out changes to the 2nd word; overrun=0.
- Reset mid-word:
  - Stimulus: 2 bits captured (bit_idx=2), then rst for 1 cycle, then pattern 0,1,0,0.
  - Response: all outputs are 0 the cycle after rst; next word_out=4'b0010, with no leftover bits.
